// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform viewer capture controller.
package wave_pkg;

  localparam int unsigned COUNT_W = 8;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned CFG_W   = 4;

  // Capture FSM encoding
  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    CAPTURING = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  // One-hot width settings
  localparam logic [CFG_W-1:0] W_SEL_1 = 4'b0001;
  localparam logic [CFG_W-1:0] W_SEL_2 = 4'b0010;
  localparam logic [CFG_W-1:0] W_SEL_3 = 4'b0100;
  localparam logic [CFG_W-1:0] W_SEL_4 = 4'b1000;

  // Height/colour code range; zero is never a legal code
  localparam logic [CFG_W-1:0] H_MIN = 4'd1;
  localparam logic [CFG_W-1:0] H_MAX = 4'd15;

endpackage

// File: rtl/wave_cfg_regs.sv
// Pending/active width and height settings; active copies update only on a frame edge.
module wave_cfg_regs
  import wave_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_w,
  input  logic             btn_h,
  input  logic             frame_edge,
  output logic [CFG_W-1:0] w,
  output logic [CFG_W-1:0] h
);

  logic [CFG_W-1:0] pending_w;
  logic [CFG_W-1:0] pending_h;
  logic [CFG_W-1:0] pending_w_nxt;
  logic [CFG_W-1:0] pending_h_nxt;

  // Button-advanced pending values; a coincident frame edge commits these updated values
  always_comb begin
    pending_w_nxt = pending_w;
    pending_h_nxt = pending_h;
    if (btn_w) begin
      pending_w_nxt = {pending_w[CFG_W-2:0], pending_w[CFG_W-1]};
    end
    if (btn_h) begin
      pending_h_nxt = (pending_h == H_MAX) ? H_MIN : pending_h + CFG_W'(1);
    end
  end

  // Pending registers track every press; active registers load between frames only
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_w <= W_SEL_1;
      pending_h <= H_MIN;
      w         <= W_SEL_1;
      h         <= H_MIN;
    end else begin
      pending_w <= pending_w_nxt;
      pending_h <= pending_h_nxt;
      if (frame_edge) begin
        w <= pending_w_nxt;
        h <= pending_h_nxt;
      end
    end
  end

endmodule

// File: rtl/wave_view_ctrl.sv
// Waveform viewer capture controller: fills one half of a double-buffered sample RAM
// while the display reads the other, swapping halves at vertical blanking.
// Define WAVE_TRIGGER_EN to start each capture on a rising zero-crossing instead of free-running.
module wave_view_ctrl
  import wave_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  input  logic                btn_w,
  input  logic                btn_h,
  output logic                write_enable,
  output logic [ADDR_W-1:0]   write_address,
  output logic [7:0]          write_sample,
  output logic                read_index,
  output logic [CFG_W-1:0]    w,
  output logic [CFG_W-1:0]    h
);

  state_t             state;
  logic [COUNT_W-1:0] count;
  logic               idle_q;
  logic               frame_edge;
  logic               trigger_ok;
  logic               do_write;
  logic [7:0]         display_sample;
  logic               unused_low_bits;

  assign frame_edge     = wave_display_idle & ~idle_q;
  assign display_sample = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};
  assign unused_low_bits = ^new_sample_in;

`ifdef WAVE_TRIGGER_EN
  logic prev_msb;

  // Sign of the previous strobed sample, tracked in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_msb <= 1'b0;
    end else if (new_sample_ready) begin
      prev_msb <= new_sample_in[SAMPLE_W-1];
    end
  end

  assign trigger_ok = prev_msb & ~new_sample_in[SAMPLE_W-1];
`else
  assign trigger_ok = 1'b1;
`endif

  assign do_write = new_sample_ready &
                    (((state == ARMED) & trigger_ok) | (state == CAPTURING));

  // Registered copy of the blanking flag for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= 1'b0;
    end else begin
      idle_q <= wave_display_idle;
    end
  end

  // Capture FSM with registered RAM write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARMED;
      count         <= '0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= {1'b1, COUNT_W'(0)};
      write_sample  <= 8'd0;
    end else begin
      write_enable <= 1'b0;
      if (do_write) begin
        write_enable  <= 1'b1;
        write_address <= {~read_index, count};
        write_sample  <= display_sample;
        count         <= count + COUNT_W'(1);
      end
      case (state)
        ARMED: begin
          if (do_write) state <= CAPTURING;
        end
        CAPTURING: begin
          if (do_write && (count == {COUNT_W{1'b1}})) state <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (frame_edge) begin
            read_index <= ~read_index;
            state      <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

  wave_cfg_regs u_cfg (
    .clk        (clk),
    .reset      (reset),
    .btn_w      (btn_w),
    .btn_h      (btn_h),
    .frame_edge (frame_edge),
    .w          (w),
    .h          (h)
  );

endmodule
